// File: rtl/jpeg_harness_pkg.sv
// Shared types and constants for the JPEG stream self-test harness.
// The optional pixel CRC is enabled with JPEG_HARNESS_CRC_EN.
package jpeg_harness_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_FLUSH,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/jpeg_harness_crc24.sv
// Combinational CRC-32 step over one {R,G,B} pixel, MSB of R first.
// Instantiated by jpeg_stream_harness only when JPEG_HARNESS_CRC_EN is defined.
module jpeg_harness_crc24
    import jpeg_harness_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [23:0] data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        crc_o = crc_i;
        for (int i = 23; i >= 0; i--) begin
            if (crc_o[31] ^ data_i[i]) crc_o = {crc_o[30:0], 1'b0} ^ CRC32_POLY;
            else                       crc_o = {crc_o[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/jpeg_stream_harness.sv
// Replays a ROM-held JPEG image plus 0x00 flush bytes into the parser and counts returned pixels.
// Define JPEG_HARNESS_CRC_EN to compute a CRC-32 over the pixel stream; otherwise pixel_crc is constant.
module jpeg_stream_harness
    import jpeg_harness_pkg::*;
#(
    parameter int ROM_AW         = 19,
    parameter int FLUSH_BYTES    = 200,
    parameter int TIMEOUT_CYCLES = 20000000,
    parameter int TMO_W          = 25,
    parameter int DIM_W          = 16,
    parameter int PIX_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROM_AW:0]   rom_len,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              parser_ready,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic              dims_valid,
    input  logic              rgb_valid,
    input  logic [23:0]       rgb_in,
    output logic [PIX_W-1:0]  pixel_cnt,
    output logic [PIX_W-1:0]  total_pixels,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [31:0]       pixel_crc
);

    localparam int FC_W = (FLUSH_BYTES > 1) ? $clog2(FLUSH_BYTES) : 1;

    state_e            state_q, state_d;
    logic [ROM_AW:0]   idx_q, idx_d;
    logic [ROM_AW:0]   len_q, len_d;
    logic [7:0]        bout_q, bout_d;
    logic              bvld_q, bvld_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [PIX_W-1:0]  tot_q, tot_d;
    logic              pass_q, pass_d;
    logic              tout_q, tout_d;
    logic              active, accept, start_ok, cnt_pix;

    assign active   = (state_q == S_FETCH) || (state_q == S_SEND) ||
                      (state_q == S_FLUSH) || (state_q == S_WAIT);
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign accept   = bvld_q && parser_ready;
    assign cnt_pix  = active && rgb_valid;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        bout_d  = bout_q;
        bvld_d  = bvld_q;
        fcnt_d  = fcnt_q;
        tmo_d   = tmo_q;
        pix_d   = pix_q;
        tot_d   = tot_q;
        pass_d  = pass_q;
        tout_d  = tout_q;

        if (cnt_pix && !(&pix_q)) pix_d = pix_q + 1'b1;
        if (active && (tot_q == '0) && dims_valid && (img_width != '0) && (img_height != '0))
            tot_d = PIX_W'(img_width) * PIX_W'(img_height);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d  = '0;
                    len_d  = rom_len;
                    fcnt_d = '0;
                    tmo_d  = '0;
                    pix_d  = '0;
                    tot_d  = '0;
                    pass_d = 1'b0;
                    tout_d = 1'b0;
                    if (rom_len != '0) begin
                        state_d = S_FETCH;
                    end else if (FLUSH_BYTES != 0) begin
                        state_d = S_FLUSH;
                        bout_d  = 8'h00;
                        bvld_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_FETCH: begin
                bout_d  = rom_data;
                bvld_d  = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (accept) begin
                    idx_d  = idx_q + 1'b1;
                    bvld_d = 1'b0;
                    if (idx_q == len_q - 1'b1) begin
                        if (FLUSH_BYTES != 0) begin
                            state_d = S_FLUSH;
                            bout_d  = 8'h00;
                            bvld_d  = 1'b1;
                            fcnt_d  = '0;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FLUSH: begin
                if (accept) begin
                    if (fcnt_q == FC_W'(FLUSH_BYTES - 1)) begin
                        bvld_d  = 1'b0;
                        state_d = S_WAIT;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Completion wins over timeout when both hold in the same cycle.
                if ((tot_q != '0) && (pix_q >= tot_q)) begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_DONE;
                    tout_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            bout_q  <= '0;
            bvld_q  <= 1'b0;
            fcnt_q  <= '0;
            tmo_q   <= '0;
            pix_q   <= '0;
            tot_q   <= '0;
            pass_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            bout_q  <= bout_d;
            bvld_q  <= bvld_d;
            fcnt_q  <= fcnt_d;
            tmo_q   <= tmo_d;
            pix_q   <= pix_d;
            tot_q   <= tot_d;
            pass_q  <= pass_d;
            tout_q  <= tout_d;
        end
    end

    // Address follows the next index so a registered ROM has the byte ready by the end of FETCH.
    assign rom_addr     = idx_d[ROM_AW-1:0];
    assign byte_out     = bout_q;
    assign byte_valid   = bvld_q;
    assign pixel_cnt    = pix_q;
    assign total_pixels = tot_q;
    assign busy         = active;
    assign done         = (state_q == S_DONE);
    assign pass         = pass_q;
    assign timeout      = tout_q;

`ifdef JPEG_HARNESS_CRC_EN
    logic [31:0] crc_q, crc_d, crc_nxt;

    jpeg_harness_crc24 u_crc (
        .crc_i  (crc_q),
        .data_i (rgb_in),
        .crc_o  (crc_nxt)
    );

    always_comb begin
        crc_d = crc_q;
        if (start_ok)     crc_d = CRC32_INIT;
        else if (cnt_pix) crc_d = crc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= CRC32_INIT;
        else     crc_q <= crc_d;
    end

    assign pixel_crc = crc_q;
`else
    logic unused_crc_inputs;
    assign unused_crc_inputs = ^{rgb_in, start_ok};
    assign pixel_crc = CRC32_INIT;
`endif

endmodule
